// File: rtl/fetch_queue.sv
// In-order (pc, instr) buffer between fetch and decode, with valid/ready handshakes
// on both sides and a synchronous flush for branch/jump redirects.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             f_valid,
    input  logic [31:0]      f_pc,
    input  logic [31:0]      f_instr,
    output logic             f_ready,
    output logic             d_valid,
    output logic [31:0]      d_pc,
    output logic [31:0]      d_instr,
    output logic [31:0]      d_pc_plus_4,
    input  logic             d_ready,
    output logic [PTR_W:0]   count
);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    always_comb begin
        f_ready = (count < (PTR_W+1)'(DEPTH));
        d_valid = (count != '0);
        push    = f_valid & f_ready & ~flush;
        pop     = d_valid & d_ready & ~flush;
    end

    // Head fields read zero when the queue is empty, so stale storage never leaks out
    always_comb begin
        d_pc        = '0;
        d_instr     = '0;
        d_pc_plus_4 = '0;
        if (d_valid) begin
            d_pc        = pc_mem[rd_ptr];
            d_instr     = instr_mem[rd_ptr];
            d_pc_plus_4 = pc_mem[rd_ptr] + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= f_pc;
            instr_mem[wr_ptr] <= f_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             f_valid;
    logic [31:0]      f_pc;
    logic [31:0]      f_instr;
    logic             f_ready;
    logic             d_valid;
    logic [31:0]      d_pc;
    logic [31:0]      d_instr;
    logic [31:0]      d_pc_plus_4;
    logic             d_ready;
    logic [PTR_W:0]   count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t model_q[$];

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        dr;
        logic        fl;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [2:0]  ecnt;
        logic        erdy;
    } vec_t;

    vec_t vecs[$];

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_ready(f_ready),
        .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .d_pc_plus_4(d_pc_plus_4),
        .d_ready(d_ready), .count(count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic fv, logic [31:0] pc, logic [31:0] instr, logic dr, logic fl,
                                logic ev, logic [31:0] epc, logic [31:0] einstr,
                                logic [2:0] ecnt, logic erdy);
        vec_t v;
        v.fv = fv; v.pc = pc; v.instr = instr; v.dr = dr; v.fl = fl;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.ecnt = ecnt; v.erdy = erdy;
        return v;
    endfunction

    // Apply inputs for one rising edge; the model advances from its pre-edge occupancy
    task automatic drive(logic fv, logic [31:0] pc, logic [31:0] instr, logic dr, logic fl);
        bit do_push;
        bit do_pop;
        entry_t e;
        f_valid = fv; f_pc = pc; f_instr = instr; d_ready = dr; flush = fl;
        do_push = fv && (model_q.size() < DEPTH) && !fl;
        do_pop  = dr && (model_q.size() > 0) && !fl;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.pc = pc; e.instr = instr;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic expect_out(string name, logic ev, logic [31:0] epc, logic [31:0] einstr,
                              logic [2:0] ecnt, logic erdy);
        logic [31:0] ep4;
        ep4 = ev ? epc + 32'd4 : 32'd0;
        vectors++;
        if (d_valid !== ev || d_pc !== epc || d_instr !== einstr || d_pc_plus_4 !== ep4 ||
            count !== ecnt || f_ready !== erdy) begin
            miscompares++;
            $display("FAIL %s: got v=%0b pc=%h instr=%h p4=%h cnt=%0d rdy=%0b, want v=%0b pc=%h instr=%h p4=%h cnt=%0d rdy=%0b",
                     name, d_valid, d_pc, d_instr, d_pc_plus_4, count, f_ready,
                     ev, epc, einstr, ep4, ecnt, erdy);
        end
    endtask

    task automatic check_model(string name);
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        ev  = (model_q.size() != 0);
        epc = ev ? model_q[0].pc : 32'd0;
        ein = ev ? model_q[0].instr : 32'd0;
        expect_out(name, ev, epc, ein, 3'(model_q.size()), model_q.size() < DEPTH);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; f_valid = 1'b0; f_pc = '0; f_instr = '0; d_ready = 1'b0;
        #12;
        expect_out("reset", 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Fill to full, blocked fifth push, then drain past empty
        vecs.push_back(mk(1, 32'h3000, 32'h20080005, 0, 0, 1, 32'h3000, 32'h20080005, 1, 1));
        vecs.push_back(mk(1, 32'h3004, 32'hAC003004, 0, 0, 1, 32'h3000, 32'h20080005, 2, 1));
        vecs.push_back(mk(1, 32'h3008, 32'hAC003008, 0, 0, 1, 32'h3000, 32'h20080005, 3, 1));
        vecs.push_back(mk(1, 32'h300C, 32'hAC00300C, 0, 0, 1, 32'h3000, 32'h20080005, 4, 0));
        vecs.push_back(mk(1, 32'h3010, 32'hAC003010, 0, 0, 1, 32'h3000, 32'h20080005, 4, 0));
        vecs.push_back(mk(1, 32'h3010, 32'hAC003010, 1, 0, 1, 32'h3004, 32'hAC003004, 3, 1));
        vecs.push_back(mk(1, 32'h3010, 32'hAC003010, 0, 0, 1, 32'h3004, 32'hAC003004, 4, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,        1, 0, 1, 32'h3008, 32'hAC003008, 3, 1));
        vecs.push_back(mk(0, 32'h0,    32'h0,        1, 0, 1, 32'h300C, 32'hAC00300C, 2, 1));
        vecs.push_back(mk(0, 32'h0,    32'h0,        1, 0, 1, 32'h3010, 32'hAC003010, 1, 1));
        vecs.push_back(mk(0, 32'h0,    32'h0,        1, 0, 0, 32'h0,    32'h0,        0, 1));
        vecs.push_back(mk(0, 32'h0,    32'h0,        1, 0, 0, 32'h0,    32'h0,        0, 1));
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].instr, vecs[i].dr, vecs[i].fl);
            expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr,
                       vecs[i].ecnt, vecs[i].erdy);
        end

        // Streaming at occupancy 2 across several pointer wraps
        drive(1, 32'h3000, 32'hAC003000, 0, 0);
        expect_out("stream_p0", 1, 32'h3000, 32'hAC003000, 3'd1, 1);
        drive(1, 32'h3004, 32'hAC003004, 0, 0);
        expect_out("stream_p1", 1, 32'h3000, 32'hAC003000, 3'd2, 1);
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h3008 + 32'(4*k), 32'hAC003008 + 32'(4*k), 1, 0);
            expect_out($sformatf("stream%0d", k), 1, 32'h3004 + 32'(4*k),
                       32'hAC003004 + 32'(4*k), 3'd2, 1);
        end

        // Flush beats a simultaneous push and pop
        drive(1, 32'h3030, 32'hAC003030, 0, 0);
        expect_out("pre_flush", 1, 32'h3028, 32'hAC003028, 3'd3, 1);
        drive(1, 32'h3020, 32'hAC003020, 1, 1);
        expect_out("flush", 0, 32'h0, 32'h0, 3'd0, 1);
        drive(1, 32'h4000, 32'h8C004000, 0, 0);
        expect_out("post_flush", 1, 32'h4000, 32'h8C004000, 3'd1, 1);
        drive(1, 32'h4004, 32'h8C004004, 0, 0);
        expect_out("pre_rst", 1, 32'h4000, 32'h8C004000, 3'd2, 1);

        // Asynchronous reset between edges
        f_valid = 1'b0; d_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        expect_out("async_rst", 0, 32'h0, 32'h0, 3'd0, 1);
        model_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;

        drive(1, 32'hFFFFFFFC, 32'h12345678, 0, 0);
        expect_out("pc_wrap", 1, 32'hFFFFFFFC, 32'h12345678, 3'd1, 1);
        vectors++;
        if (d_pc_plus_4 !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_plus_4_wrap: got %h want 00000000", d_pc_plus_4);
        end
        drive(0, 32'h0, 32'h0, 1, 0);
        check_model("drain");

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 7, {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            check_model($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
